// File: rtl/imem_loader.sv
// imem_loader: receives a byte stream (4-byte little-endian word count, then
// count little-endian 32-bit words) and writes it into instruction memory,
// holding the CPU in reset until a session completes successfully.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a load session (honoured in IDLE/DONE/ERR)
//   byte_valid/byte_data stream input; a byte moves when byte_valid && byte_ready
//   byte_ready           loader accepts a byte this cycle
//   mem_we/mem_addr/     one-cycle memory write strobe, word-aligned byte
//   mem_wdata            address and write data
//   busy, done, error    session status
//   cpu_hold             CPU reset hold, low only after a successful load
module imem_loader #(
  parameter int unsigned N    = 32,
  parameter int unsigned SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         cpu_hold
);

  localparam int unsigned CW = 32;

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

  state_t        state;
  state_t        nxt;
  logic [1:0]    bcnt;
  logic [23:0]   shreg;
  logic [CW-1:0] count;
  logic [CW-1:0] word_idx;

  logic          accept_c;
  logic          last_byte_c;
  logic          too_big_c;
  logic          restart_c;
  logic [CW-1:0] shreg_nxt_c;

  logic byte_ready_d, busy_d, done_d, error_d, cpu_hold_d, mem_we_d;

  // Stream handshake and little-endian assembly: the newest byte lands on top,
  // so after four bytes the first one sits in bits [7:0].
  assign accept_c    = byte_valid && byte_ready;
  assign last_byte_c = accept_c && (bcnt == 2'd3);
  assign shreg_nxt_c = {byte_data, shreg};
  assign too_big_c   = {1'b0, shreg_nxt_c} > 33'(SIZE);
  assign restart_c   = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state      <= nxt;
      byte_ready <= byte_ready_d;
      mem_we     <= mem_we_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      cpu_hold   <= cpu_hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) nxt = LEN;
      LEN: begin
        if (last_byte_c) begin
          if (shreg_nxt_c == '0) nxt = DONE;
          else if (too_big_c)    nxt = ERR;
          else                   nxt = DATA;
        end
      end
      DATA:  if (last_byte_c) nxt = WRITE;
      WRITE: nxt = ((word_idx + 32'd1) == count) ? DONE : DATA;
      default: nxt = IDLE;
    endcase
  end

  // Output decode, applied to the next state so the flops match the state.
  always_comb begin
    byte_ready_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    cpu_hold_d   = 1'b1;
    mem_we_d     = 1'b0;
    unique case (nxt)
      LEN, DATA: begin
        byte_ready_d = 1'b1;
        busy_d       = 1'b1;
      end
      WRITE: begin
        busy_d   = 1'b1;
        mem_we_d = 1'b1;
      end
      DONE: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      ERR:     error_d = 1'b1;
      default: ;
    endcase
  end

  // Byte counter, word count, word index and the write address/data registers.
  // Address and data are loaded on the edge that enters WRITE and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt      <= '0;
      shreg     <= '0;
      count     <= '0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (restart_c) begin
      bcnt     <= '0;
      count    <= '0;
      word_idx <= '0;
    end else begin
      if (accept_c) begin
        bcnt  <= bcnt + 2'd1;
        shreg <= shreg_nxt_c[31:8];
      end
      if ((state == LEN) && last_byte_c) begin
        count <= shreg_nxt_c;
      end
      if ((state == DATA) && last_byte_c) begin
        mem_addr  <= N'(word_idx << 2);
        mem_wdata <= N'(shreg_nxt_c);
      end
      if (state == WRITE) begin
        word_idx <= word_idx + 32'd1;
      end
    end
  end

endmodule
